// File: rtl/irq_ctrl.sv
// irq_ctrl: four-source edge-capturing interrupt controller with fixed priority
// (bit 0 highest), a REQ/ACK handshake to the CPU and a MASK/PENDING/STATUS bus window.
module irq_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'hF0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] IRQ_IN,
    output logic [3:0] IRQ_ACK,
    output logic       CPU_IRQ,
    output logic [1:0] CPU_IRQ_ID,
    input  logic       CPU_IRQ_ACK,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE
);

    localparam logic [7:0] ADDR_MASK = BASE_ADDR;
    localparam logic [7:0] ADDR_PEND = BASE_ADDR + 8'd1;
    localparam logic [7:0] ADDR_STAT = BASE_ADDR + 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_irq_q;
    logic [3:0] r_pending;
    logic [3:0] r_mask;
    logic [3:0] r_elig_q;
    logic [1:0] r_id;
    logic [1:0] w_id_nxt;
    logic       r_cpu_irq;
    logic       w_cpu_irq_nxt;
    logic [3:0] r_irq_ack;
    logic [3:0] w_irq_ack_nxt;
    logic [3:0] w_ack_clr;
    logic       r_rd_en;
    logic [7:0] r_rd_data;

    logic       w_sel_mask;
    logic       w_sel_pend;
    logic       w_sel_stat;
    logic       w_in_win;
    logic       w_wr_mask;
    logic       w_wr_pend;
    logic       w_rd_req;
    logic [3:0] w_rise;
    logic [3:0] w_w1c;
    logic [3:0] w_eligible;
    logic [7:0] w_rd_mux;
    logic       w_unused_hi;

    function automatic logic [1:0] f_lowest(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    assign w_sel_mask  = (BUS_ADDR == ADDR_MASK);
    assign w_sel_pend  = (BUS_ADDR == ADDR_PEND);
    assign w_sel_stat  = (BUS_ADDR == ADDR_STAT);
    assign w_in_win    = w_sel_mask | w_sel_pend | w_sel_stat;
    assign w_wr_mask   = BUS_WE & w_sel_mask;
    assign w_wr_pend   = BUS_WE & w_sel_pend;
    assign w_rd_req    = ~BUS_WE & w_in_win;
    assign w_unused_hi = ^BUS_DATA[7:4];

    assign w_rise = IRQ_IN & ~r_irq_q;
    assign w_w1c  = w_wr_pend ? BUS_DATA[3:0] : 4'h0;

    // One qualification cycle before IDLE may act; re-gating with the live
    // pending/mask keeps a just-cleared or just-masked source from being served.
    assign w_eligible = r_elig_q & r_pending & r_mask;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_irq_q   <= 4'h0;
            r_pending <= 4'h0;
            r_mask    <= 4'hF;
            r_elig_q  <= 4'h0;
        end else begin
            r_irq_q   <= IRQ_IN;
            r_pending <= (r_pending & ~(w_w1c | w_ack_clr)) | w_rise;
            r_elig_q  <= r_pending & r_mask;
            if (w_wr_mask) begin
                r_mask <= BUS_DATA[3:0];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_id_nxt      = r_id;
        w_cpu_irq_nxt = r_cpu_irq;
        w_irq_ack_nxt = 4'h0;
        w_ack_clr     = 4'h0;
        case (r_state)
            ST_IDLE: begin
                if (|w_eligible) begin
                    w_state_nxt   = ST_REQ;
                    w_id_nxt      = f_lowest(w_eligible);
                    w_cpu_irq_nxt = 1'b1;
                end
            end
            ST_REQ: begin
                if (CPU_IRQ_ACK) begin
                    w_state_nxt   = ST_ACK;
                    w_cpu_irq_nxt = 1'b0;
                    w_irq_ack_nxt = 4'b0001 << r_id;
                    w_ack_clr     = 4'b0001 << r_id;
                end
            end
            ST_ACK: begin
                // Guard cycle: lets the acknowledged source drop its level.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_cpu_irq_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_id      <= 2'd0;
            r_cpu_irq <= 1'b0;
            r_irq_ack <= 4'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_id      <= w_id_nxt;
            r_cpu_irq <= w_cpu_irq_nxt;
            r_irq_ack <= w_irq_ack_nxt;
        end
    end

    always_comb begin
        w_rd_mux = 8'h00;
        if (w_sel_mask) begin
            w_rd_mux = {4'h0, r_mask};
        end else if (w_sel_pend) begin
            w_rd_mux = {4'h0, r_pending};
        end else if (w_sel_stat) begin
            w_rd_mux = {5'h00, r_cpu_irq, r_id};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_en <= 1'b0;
        end else begin
            r_rd_en <= w_rd_req;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_rd_req) begin
            r_rd_data <= w_rd_mux;
        end
    end

    assign BUS_DATA   = r_rd_en ? r_rd_data : 8'hzz;
    assign IRQ_ACK    = r_irq_ack;
    assign CPU_IRQ    = r_cpu_irq;
    assign CPU_IRQ_ID = r_id;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed-vector bench for irq_ctrl: a per-cycle table of inputs and expected
// outputs, followed by hand-written reset-abort and reset-release sequences.
module tb_irq_ctrl;

    localparam logic [7:0] BASE = 8'hF0;
    localparam int NV = 41;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic [3:0] irq_ack;
    logic       cpu_irq;
    logic [1:0] cpu_id;
    logic       cpu_ack;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic       drv_en;
    logic [7:0] drv_data;
    tri1  [7:0] bus_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] irq;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       ack;
        logic       e_cpu;
        logic [1:0] e_id;
        logic [3:0] e_iack;
        logic [7:0] e_bus;
    } vec_t;

    vec_t tbl [NV];

    assign bus_data = drv_en ? drv_data : 8'hzz;

    always #5 clk = ~clk;

    irq_ctrl #(.BASE_ADDR(BASE)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .IRQ_IN     (irq_in),
        .IRQ_ACK    (irq_ack),
        .CPU_IRQ    (cpu_irq),
        .CPU_IRQ_ID (cpu_id),
        .CPU_IRQ_ACK(cpu_ack),
        .BUS_DATA   (bus_data),
        .BUS_ADDR   (bus_addr),
        .BUS_WE     (bus_we)
    );

    function automatic vec_t mk(input logic [3:0] irq, input logic we, input logic [7:0] a,
                                input logic [7:0] d, input logic ack, input logic c,
                                input logic [1:0] id, input logic [3:0] ia, input logic [7:0] b);
        vec_t v;
        v.irq = irq; v.we = we; v.addr = a; v.wdata = d; v.ack = ack;
        v.e_cpu = c; v.e_id = id; v.e_iack = ia; v.e_bus = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Packs observed outputs as hex digits: cpu_irq, id, irq_ack, bus(2 digits).
    function automatic logic [31:0] pack(input logic c, input logic [1:0] id,
                                         input logic [3:0] ia, input logic [7:0] b);
        return {15'h0, c, 2'b00, id, ia, b};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // irq   we    addr   wdata ack | cpu id  iack  bus
        tbl[0]  = mk(4'h1, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF);
        tbl[1]  = mk(4'h1, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF);
        tbl[2]  = mk(4'h1, 0, 8'h00, 8'h00, 0, 1, 0, 4'h0, 8'hFF);
        tbl[3]  = mk(4'h1, 0, 8'h00, 8'h00, 0, 1, 0, 4'h0, 8'hFF);
        tbl[4]  = mk(4'h1, 0, 8'h00, 8'h00, 1, 0, 0, 4'h1, 8'hFF);
        tbl[5]  = mk(4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF);
        tbl[6]  = mk(4'h0, 0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 8'h00);
        tbl[7]  = mk(4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF);
        tbl[8]  = mk(4'hA, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF);
        tbl[9]  = mk(4'hA, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF);
        tbl[10] = mk(4'hA, 0, 8'h00, 8'h00, 0, 1, 1, 4'h0, 8'hFF);
        tbl[11] = mk(4'hA, 0, 8'h00, 8'h00, 1, 0, 1, 4'h2, 8'hFF);
        tbl[12] = mk(4'h8, 0, 8'h00, 8'h00, 1, 0, 1, 4'h0, 8'hFF);
        tbl[13] = mk(4'h8, 0, 8'h00, 8'h00, 0, 1, 3, 4'h0, 8'hFF);
        tbl[14] = mk(4'h8, 0, 8'h00, 8'h00, 1, 0, 3, 4'h8, 8'hFF);
        tbl[15] = mk(4'h0, 0, 8'h00, 8'h00, 0, 0, 3, 4'h0, 8'hFF);
        tbl[16] = mk(4'h0, 0, 8'h00, 8'h00, 1, 0, 3, 4'h0, 8'hFF);
        tbl[17] = mk(4'h0, 1, 8'hF0, 8'h0E, 0, 0, 3, 4'h0, 8'h0E);
        tbl[18] = mk(4'h1, 0, 8'h00, 8'h00, 0, 0, 3, 4'h0, 8'hFF);
        tbl[19] = mk(4'h1, 0, 8'h00, 8'h00, 0, 0, 3, 4'h0, 8'hFF);
        tbl[20] = mk(4'h1, 0, 8'hF1, 8'h00, 0, 0, 3, 4'h0, 8'h01);
        tbl[21] = mk(4'h1, 0, 8'h00, 8'h00, 0, 0, 3, 4'h0, 8'hFF);
        tbl[22] = mk(4'h1, 1, 8'hF0, 8'h0F, 0, 0, 3, 4'h0, 8'h0F);
        tbl[23] = mk(4'h1, 0, 8'h00, 8'h00, 0, 0, 3, 4'h0, 8'hFF);
        tbl[24] = mk(4'h1, 0, 8'h00, 8'h00, 0, 1, 0, 4'h0, 8'hFF);
        tbl[25] = mk(4'h1, 0, 8'hF0, 8'h00, 0, 1, 0, 4'h0, 8'h0F);
        tbl[26] = mk(4'h1, 0, 8'hF2, 8'h00, 0, 1, 0, 4'h0, 8'h04);
        tbl[27] = mk(4'h1, 0, 8'h00, 8'h00, 0, 1, 0, 4'h0, 8'hFF);
        tbl[28] = mk(4'h1, 1, 8'hF0, 8'h0E, 0, 1, 0, 4'h0, 8'h0E);
        tbl[29] = mk(4'h1, 1, 8'hF1, 8'h01, 0, 1, 0, 4'h0, 8'h01);
        tbl[30] = mk(4'h1, 1, 8'hF0, 8'h0F, 0, 1, 0, 4'h0, 8'h0F);
        tbl[31] = mk(4'h1, 0, 8'h00, 8'h00, 1, 0, 0, 4'h1, 8'hFF);
        tbl[32] = mk(4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF);
        tbl[33] = mk(4'h0, 0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 8'h00);
        tbl[34] = mk(4'h0, 0, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'hFF);
        tbl[35] = mk(4'h4, 1, 8'hF1, 8'h04, 0, 0, 0, 4'h0, 8'h04);
        tbl[36] = mk(4'h4, 0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 8'h04);
        tbl[37] = mk(4'h4, 0, 8'h00, 8'h00, 0, 1, 2, 4'h0, 8'hFF);
        tbl[38] = mk(4'h4, 0, 8'hF2, 8'h00, 0, 1, 2, 4'h0, 8'h06);
        tbl[39] = mk(4'h5, 0, 8'h00, 8'h00, 0, 1, 2, 4'h0, 8'hFF);
        tbl[40] = mk(4'h5, 0, 8'h00, 8'h00, 0, 1, 2, 4'h0, 8'hFF);

        rst      = 1'b1;
        irq_in   = 4'h0;
        cpu_ack  = 1'b0;
        bus_addr = 8'h00;
        bus_we   = 1'b0;
        drv_en   = 1'b0;
        drv_data = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", pack(cpu_irq, cpu_id, irq_ack, bus_data), pack(0, 0, 4'h0, 8'hFF));
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            irq_in   = tbl[i].irq;
            bus_we   = tbl[i].we;
            bus_addr = tbl[i].addr;
            drv_en   = tbl[i].we;
            drv_data = tbl[i].wdata;
            cpu_ack  = tbl[i].ack;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d cpu/id/ack/bus", i),
                pack(cpu_irq, cpu_id, irq_ack, bus_data),
                pack(tbl[i].e_cpu, tbl[i].e_id, tbl[i].e_iack, tbl[i].e_bus));
        end

        // Reset mid-REQ: outputs drop without a clock edge, no ACK while held.
        #2;
        rst = 1'b1;
        #1;
        chk("reset midREQ async", pack(cpu_irq, cpu_id, irq_ack, bus_data), pack(0, 0, 4'h0, 8'hFF));
        cpu_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ack during reset", pack(cpu_irq, cpu_id, irq_ack, bus_data), pack(0, 0, 4'h0, 8'hFF));

        // Release with IRQ_IN=0101 still high: both sources recaptured as new edges.
        cpu_ack  = 1'b0;
        bus_addr = BASE;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        chk("mask after reset", {24'h0, bus_data}, 32'h0F);
        bus_addr = BASE + 8'd1;
        @(posedge clk);
        #1;
        chk("pending after release", pack(cpu_irq, cpu_id, irq_ack, bus_data), pack(0, 0, 4'h0, 8'h05));
        bus_addr = 8'h00;
        @(posedge clk);
        #1;
        chk("recapture request", pack(cpu_irq, cpu_id, irq_ack, bus_data), pack(1, 0, 4'h0, 8'hFF));

        // Reset mid-ACK: the pulse in flight is cut off immediately.
        cpu_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("ack pulse id0", pack(cpu_irq, cpu_id, irq_ack, bus_data), pack(0, 0, 4'h1, 8'hFF));
        cpu_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("reset midACK async", {28'h0, irq_ack}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 8'hF0, giving the bus base address of the three-register window BASE_ADDR..BASE_ADDR+2.
REQ-002 The block SHALL have port CLK, input, 1 bit: system clock, 50 MHz.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port IRQ_IN, input, 4 bits: level interrupt requests from peripherals (bit 0 = switch SEND_INTERRUPT), each held high by its source until acknowledged.
REQ-005 The block SHALL have port IRQ_ACK, output, 4 bits: per-source one-cycle acknowledge pulse.
REQ-006 The block SHALL have port CPU_IRQ, output, 1 bit: interrupt request to the CPU.
REQ-007 The block SHALL have port CPU_IRQ_ID, output, 2 bits: index of the source being presented on CPU_IRQ.
REQ-008 The block SHALL have port CPU_IRQ_ACK, input, 1 bit: one-cycle acknowledge from the CPU.
REQ-009 The block SHALL have port BUS_DATA, inout, 8 bits: shared data bus.
REQ-010 The block SHALL have port BUS_ADDR, input, 8 bits: bus address.
REQ-011 The block SHALL have port BUS_WE, input, 1 bit: bus write enable, high = write.

Function
REQ-012 Edge detection: each IRQ_IN bit SHALL be registered once (irq_q); pending[i] SHALL set on the cycle after IRQ_IN[i]=1 while irq_q[i]=0.
REQ-013 Pending clear: pending[i] SHALL clear on (a) the internal ACK of source i, or (b) a bus write to BASE_ADDR+1 with data bit i=1 (write-1-to-clear).
REQ-014 Set vs. clear: if a set and a clear hit the same bit in the same cycle, set SHALL win.
REQ-015 MASK register (BASE_ADDR+0, RW, bits 3:0, reset 4'hF): eligible = pending & mask; data bits 7:4 SHALL be ignored on write and read back as 0.
REQ-016 Register reads: BASE_ADDR+1 SHALL read {4'b0, pending}; BASE_ADDR+2 SHALL read {5'b0, CPU_IRQ, CPU_IRQ_ID}.
REQ-017 Bus read timing: BUS_DATA SHALL be driven on the cycle after a read address (BUS_WE=0) inside the window is sampled, using registered enable and data, and SHALL be high-Z otherwise.
REQ-018 Writes: a write SHALL take effect at the CLK edge where BUS_WE=1 and the address matches; writes to BASE_ADDR+2 SHALL be ignored.
REQ-019 State machine: the block SHALL implement states IDLE, REQ and ACK.
REQ-020 IDLE -> REQ: when eligible is non-zero, the block SHALL latch id = lowest set index (bit 0 highest priority) and assert CPU_IRQ=1 and CPU_IRQ_ID=id from the next cycle.
REQ-021 REQ: CPU_IRQ and CPU_IRQ_ID SHALL hold stable regardless of new pending bits, mask writes, or a W1C of pending[id].
REQ-022 REQ -> ACK: on CPU_IRQ_ACK=1, the block SHALL deassert CPU_IRQ next cycle, pulse IRQ_ACK[id] for exactly one cycle, and clear pending[id].
REQ-023 ACK -> IDLE: the transition SHALL be unconditional after one cycle, giving one guard cycle so the source can drop its request.
REQ-024 CPU_IRQ_ACK while in IDLE or ACK SHALL be ignored.
REQ-025 Latency: from an IRQ_IN rising edge to CPU_IRQ=1 SHALL be 3 cycles when idle and the source is unmasked.
REQ-026 Back-to-back: after ACK the block SHALL serve the next eligible source directly with no extra idle cycles beyond IDLE evaluation, so CPU_IRQ is low for at least 2 cycles between requests.

Reset
REQ-027 While RESET=1, the block SHALL asynchronously force: state=IDLE, pending=0, irq_q=0, mask=4'hF, CPU_IRQ=0, CPU_IRQ_ID=0, IRQ_ACK=0, and read enable=0 (BUS_DATA high-Z).
REQ-028 A reset asserted mid-REQ or mid-ACK SHALL abort without emitting IRQ_ACK.
REQ-029 A source still high at reset release SHALL be captured as a new edge, because irq_q resets to 0.

Verification
REQ-030 Single request: IRQ_IN=4'b0001 at cycle 0 -> CPU_IRQ=1, CPU_IRQ_ID=0 at cycle 3; CPU_IRQ_ACK pulse -> IRQ_ACK=4'b0001 for one cycle, pending=0.
REQ-031 Priority: IRQ_IN=4'b1010 simultaneously -> ID=1 served first, then ID=3; CPU_IRQ low for at least 2 cycles between them.
REQ-032 Masking: write 8'h0E to BASE_ADDR, raise IRQ_IN[0] -> no CPU_IRQ and BASE_ADDR+1 reads 8'h01; then write 8'h0F -> CPU_IRQ=1, ID=0.
REQ-033 Set/clear collision: W1C 8'h04 to BASE_ADDR+1 in the same cycle as an IRQ_IN[2] set -> pending[2] remains 1.
REQ-034 Bus read: address BASE_ADDR+2 with WE=0 while in REQ with ID=2 -> BUS_DATA=8'h06 on the next cycle, and high-Z once the address leaves the window.
REQ-035 Reset mid-REQ: assert RESET while CPU_IRQ=1 -> all outputs 0 immediately, mask=8'h0F, and no IRQ_ACK pulse.
